// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART transmit FIFO.
// One requester holds the grant for a whole packet. An optional header
// byte {5'b10100, id} is sent first. A packet longer than MAX_LEN bytes
// is cut after MAX_LEN bytes; its remaining bytes then compete as a new
// packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 64,
    parameter int INSERT_HDR = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [7:0]             fifo_data,
    output logic [2:0]             gnt_id,
    output logic                   busy,
    output logic                   err_trunc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]  gnt_id_q, gnt_id_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_trunc_q, err_trunc_d;

    // Requester inputs widened to the full 3-bit ID space so that any ID
    // can index them without width mismatches.
    logic [7:0]  valid_pad_s;
    logic [7:0]  last_pad_s;
    logic [7:0]  data_arr_s [8];

    logic        pick_found_s;
    logic [2:0]  pick_idx_s;
    logic        beat_s;
    logic        last_s;
    logic [7:0]  cnt_inc_s;
    logic        at_max_s;

    // Next requester index after idx, wrapping to 0 after NUM_REQ-1.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        if (idx == 3'(NUM_REQ - 1)) begin
            return 3'd0;
        end else begin
            return idx + 3'd1;
        end
    endfunction

    // Widen the per-requester inputs to eight lanes; unused lanes read as zero.
    always_comb begin
        valid_pad_s = 8'd0;
        last_pad_s  = 8'd0;
        for (int i = 0; i < 8; i++) begin
            data_arr_s[i] = 8'd0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_pad_s[i] = req_valid[i];
            last_pad_s[i]  = req_last[i];
            data_arr_s[i]  = req_data[8*i +: 8];
        end
    end

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        logic [2:0] cand_s;
        pick_found_s = 1'b0;
        pick_idx_s   = 3'd0;
        cand_s       = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found_s && valid_pad_s[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_idx_s   = pick_idx_s;
            end
            cand_s = next_idx(cand_s);
        end
    end

    // Data-phase handshake and packet-length tracking for the granted requester.
    always_comb begin
        beat_s    = (state_q == ST_DATA) && valid_pad_s[gnt_id_q] && !fifo_full;
        last_s    = last_pad_s[gnt_id_q];
        cnt_inc_s = cnt_q + 8'd1;
        at_max_s  = (cnt_inc_s == 8'(MAX_LEN));
    end

    // State, round-robin pointer, grant, beat counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 3'd0;
            gnt_id_q    <= 3'd0;
            cnt_q       <= 8'd0;
            err_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            cnt_q       <= cnt_d;
            err_trunc_q <= err_trunc_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, send header, stream data until last or MAX_LEN.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        cnt_d       = cnt_q;
        err_trunc_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    gnt_id_d = pick_idx_s;
                    cnt_d    = 8'd0;
                    if (INSERT_HDR != 0) begin
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!fifo_full) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (beat_s) begin
                    cnt_d = cnt_inc_s;
                    if (last_s || at_max_s) begin
                        state_d     = ST_IDLE;
                        rr_ptr_d    = next_idx(gnt_id_q);
                        err_trunc_d = !last_s;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: FIFO write strobe/data and the single granted ready bit.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        fifo_wr_en = 1'b0;
        fifo_data  = 8'd0;
        req_ready  = {NUM_REQ{1'b0}};
        case (state_q)
            ST_HDR: begin
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    fifo_data = {5'b10100, gnt_id_q};
                end else begin
                    fifo_data = 8'd0;
                end
            end
            ST_DATA: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt_id_q == 3'(i)) begin
                        req_ready[i] = !fifo_full;
                    end else begin
                        req_ready[i] = 1'b0;
                    end
                end
                fifo_wr_en = beat_s;
                if (beat_s) begin
                    fifo_data = data_arr_s[gnt_id_q];
                end else begin
                    fifo_data = 8'd0;
                end
            end
            default: begin
                fifo_wr_en = 1'b0;
                fifo_data  = 8'd0;
            end
        endcase
    end

    assign gnt_id    = gnt_id_q;
    assign err_trunc = err_trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected
// {gnt_id, byte} pairs; a monitor pops one on every FIFO write.
// A second instance without headers covers the single-byte case.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NR-1:0]   req_valid, req_last, req_ready;
    logic [8*NR-1:0] req_data;
    logic            fifo_full, fifo_wr_en;
    logic [7:0]      fifo_data;
    logic [2:0]      gnt_id;
    logic            busy, err_trunc;

    logic [NR-1:0]   nh_valid, nh_last, nh_ready;
    logic [8*NR-1:0] nh_data;
    logic            nh_wr_en;
    logic [7:0]      nh_fdata;
    logic [2:0]      nh_gnt;
    logic            nh_busy, nh_err;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(64), .INSERT_HDR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
        .gnt_id(gnt_id), .busy(busy), .err_trunc(err_trunc)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(64), .INSERT_HDR(0)) dut_nh (
        .clk(clk), .rst_n(rst_n),
        .req_valid(nh_valid), .req_data(nh_data), .req_last(nh_last),
        .req_ready(nh_ready), .fifo_full(fifo_full),
        .fifo_wr_en(nh_wr_en), .fifo_data(nh_fdata),
        .gnt_id(nh_gnt), .busy(nh_busy), .err_trunc(nh_err)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [10:0] exp_q [$];
    logic [10:0] mon_e;
    logic [8:0]  src_mem [NR][128];
    int          src_wr [NR];
    int          src_rd [NR];
    logic        full_plan;
    int          err_cnt = 0;
    int          nh_wr_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic [7:0] b);
        exp_q.push_back({g, b});
    endtask

    task automatic load(input int r, input logic [7:0] b, input logic l);
        src_mem[r][src_wr[r]] = {l, b};
        src_wr[r]++;
    endtask

    // Present each requester's next queued byte (or nothing) and the planned full flag.
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
                req_last[i]        = src_mem[i][src_rd[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        fifo_full = full_plan;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
    endtask

    // Called at a negedge: record handshakes, advance one clock, return at next negedge.
    task automatic step();
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) src_rd[i]++;
        end
        drive();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || (|req_valid)) && n < 400) begin
            step();
            n++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected pair.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_write_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got gnt %0d data 0x%02h, expected no write at %0t",
                             gnt_id, fifo_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("fifo_write", {21'd0, gnt_id, fifo_data}, {21'd0, mon_e});
                end
            end else begin
                chk("idle_data_zero", {24'd0, fifo_data}, 32'd0);
            end
            if (err_trunc) err_cnt++;
            if (nh_wr_en) nh_wr_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        full_plan = 1'b0;
        clear_src();
        drive();
        nh_valid = '0;
        nh_last  = '0;
        nh_data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        chk("rst_err", 32'(err_trunc), 32'd0);
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Test 1: requester 2 sends 11,22,33 with header A2
        load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
        push(3'd2, 8'hA2); push(3'd2, 8'h11); push(3'd2, 8'h22); push(3'd2, 8'h33);
        step();
        chk("t1_arb_busy", 32'(busy), 32'd0);
        chk("t1_arb_wr", 32'(fifo_wr_en), 32'd0);
        step();
        chk("t1_hdr_wr", 32'(fifo_wr_en), 32'd1);
        chk("t1_hdr_busy", 32'(busy), 32'd1);
        chk("t1_hdr_gnt", 32'(gnt_id), 32'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_data_wr", 32'(fifo_wr_en), 32'd1);
            chk("t1_data_ready", 32'(req_ready), 32'b0100);
        end
        step();
        chk("t1_end_busy", 32'(busy), 32'd0);
        chk("t1_end_wr", 32'(fifo_wr_en), 32'd0);
        chk("t1_end_gnt", 32'(gnt_id), 32'd2);

        // Test 2: all four requesters pending -> order 0,1,2,3,0
        do_reset();
        for (int r = 0; r < NR; r++) begin
            load(r, 8'(16*r + 1), 1'b0);
            load(r, 8'(16*r + 2), 1'b1);
        end
        load(0, 8'h03, 1'b0); load(0, 8'h04, 1'b1);
        push(3'd0, 8'hA0); push(3'd0, 8'h01); push(3'd0, 8'h02);
        push(3'd1, 8'hA1); push(3'd1, 8'h11); push(3'd1, 8'h12);
        push(3'd2, 8'hA2); push(3'd2, 8'h21); push(3'd2, 8'h22);
        push(3'd3, 8'hA3); push(3'd3, 8'h31); push(3'd3, 8'h32);
        push(3'd0, 8'hA0); push(3'd0, 8'h03); push(3'd0, 8'h04);
        drain("t2");

        // Test 3: fifo_full for 5 cycles mid-packet (rr_ptr now 1)
        for (int k = 0; k < 6; k++) load(1, 8'(8'h41 + k), (k == 5));
        push(3'd1, 8'hA1);
        for (int k = 0; k < 6; k++) push(3'd1, 8'(8'h41 + k));
        repeat (4) step();
        full_plan = 1'b1;
        repeat (5) begin
            step();
            chk("t3_full_wr", 32'(fifo_wr_en), 32'd0);
            chk("t3_full_ready", 32'(req_ready), 32'd0);
            chk("t3_full_busy", 32'(busy), 32'd1);
        end
        full_plan = 1'b0;
        drain("t3");

        // Test 4: requester 1 streams 70 bytes, cut at 64; requester 3 pending
        do_reset();
        err_cnt = 0;
        for (int k = 0; k < 70; k++) load(1, 8'(8'h80 + k), (k == 69));
        load(3, 8'h71, 1'b0); load(3, 8'h72, 1'b1);
        push(3'd1, 8'hA1);
        for (int k = 0; k < 64; k++) push(3'd1, 8'(8'h80 + k));
        push(3'd3, 8'hA3); push(3'd3, 8'h71); push(3'd3, 8'h72);
        push(3'd1, 8'hA1);
        for (int k = 64; k < 70; k++) push(3'd1, 8'(8'h80 + k));
        drain("t4");
        chk("t4_err_pulses", 32'(err_cnt), 32'd1);

        // Test 5: async reset after the 2nd data byte (rr_ptr now 2)
        for (int k = 0; k < 4; k++) load(2, 8'(8'h91 + k), (k == 3));
        push(3'd2, 8'hA2); push(3'd2, 8'h91); push(3'd2, 8'h92);
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        chk("t5_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t5_data", 32'(fifo_data), 32'd0);
        chk("t5_gnt", 32'(gnt_id), 32'd0);
        chk("t5_err", 32'(err_trunc), 32'd0);
        clear_src();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        load(1, 8'hB1, 1'b1); load(3, 8'hB3, 1'b1);
        push(3'd1, 8'hA1); push(3'd1, 8'hB1); push(3'd3, 8'hA3); push(3'd3, 8'hB3);
        drain("t5");

        // Test 6: no header, requester 3 sends 0x5A, then rr_ptr wraps to 0
        @(posedge clk); #1;
        nh_valid = 4'b1000; nh_data = 32'h5A00_0000; nh_last = 4'b1000;
        @(negedge clk);
        chk("t6_arb_wr", 32'(nh_wr_en), 32'd0);
        chk("t6_arb_busy", 32'(nh_busy), 32'd0);
        @(negedge clk);
        chk("t6_wr", 32'(nh_wr_en), 32'd1);
        chk("t6_data", 32'(nh_fdata), 32'h5A);
        chk("t6_gnt", 32'(nh_gnt), 32'd3);
        chk("t6_ready", 32'(nh_ready), 32'b1000);
        @(posedge clk); #1;
        nh_valid = '0; nh_data = '0; nh_last = '0;
        @(negedge clk);
        chk("t6_done_busy", 32'(nh_busy), 32'd0);
        chk("t6_done_wr", 32'(nh_wr_en), 32'd0);
        @(posedge clk); #1;
        nh_valid = 4'b1001; nh_data = 32'h5B00_000C; nh_last = 4'b1001;
        @(negedge clk);
        chk("t6_arb2_wr", 32'(nh_wr_en), 32'd0);
        @(negedge clk);
        chk("t6_wrap_gnt", 32'(nh_gnt), 32'd0);
        chk("t6_wrap_data", 32'(nh_fdata), 32'h0C);
        @(posedge clk); #1;
        nh_valid = 4'b1000; nh_data = 32'h5B00_0000; nh_last = 4'b1000;
        @(negedge clk);
        chk("t6_arb3_wr", 32'(nh_wr_en), 32'd0);
        @(negedge clk);
        chk("t6_r3_gnt", 32'(nh_gnt), 32'd3);
        chk("t6_r3_data", 32'(nh_fdata), 32'h5B);
        @(posedge clk); #1;
        nh_valid = '0; nh_data = '0; nh_last = '0;
        @(negedge clk);
        chk("t6_writes", 32'(nh_wr_cnt), 32'd3);
        chk("t6_err", 32'(nh_err), 32'd0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
